// File: rtl/sum_arb_seq.sv
// Two-requester round-robin arbiter in front of a nibble-serial adder.
// One shared 4-bit ripple slice processes the granted operands LSB nibble first.
module sum_arb_seq #(
  parameter int unsigned NIBBLES = 4,
  parameter int unsigned W       = 4 * NIBBLES
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0,
  input  logic [W-1:0] a0,
  input  logic [W-1:0] b0,
  input  logic         ci0,
  input  logic         req1,
  input  logic [W-1:0] a1,
  input  logic [W-1:0] b1,
  input  logic         ci1,
  output logic         gnt0,
  output logic         gnt1,
  output logic         busy,
  output logic         done,
  output logic         owner,
  output logic [W-1:0] sum,
  output logic         co
);

  localparam int unsigned KW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [KW-1:0] KLast = KW'(NIBBLES - 1);

  typedef enum logic [1:0] {StIdle, StAdd, StDone} state_e;

  state_e        state_q;
  logic [KW-1:0] k_q;
  logic          ptr_q;
  logic          sel_q;
  logic [W-1:0]  wa_q;
  logic [W-1:0]  wb_q;
  logic [W-1:0]  wsum_q;
  logic          carry_q;

  logic          pick;
  logic [3:0]    a_nib;
  logic [3:0]    b_nib;
  logic [3:0]    slice_so;
  logic          slice_co;
  logic [W-1:0]  wsum_upd;

  // Contention goes to the pointer; a lone requester always wins.
  always_comb begin
    pick = (req0 & req1) ? ptr_q : req1;
  end

  always_comb begin
    a_nib                 = wa_q[4*k_q +: 4];
    b_nib                 = wb_q[4*k_q +: 4];
    {slice_co, slice_so}  = {1'b0, a_nib} + {1'b0, b_nib} + {4'b0000, carry_q};
    wsum_upd              = wsum_q;
    wsum_upd[4*k_q +: 4]  = slice_so;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      k_q     <= '0;
      ptr_q   <= 1'b0;
      sel_q   <= 1'b0;
      wa_q    <= '0;
      wb_q    <= '0;
      wsum_q  <= '0;
      carry_q <= 1'b0;
      gnt0    <= 1'b0;
      gnt1    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      owner   <= 1'b0;
      sum     <= '0;
      co      <= 1'b0;
    end else begin
      gnt0 <= 1'b0;
      gnt1 <= 1'b0;
      done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (req0 | req1) begin
            gnt0    <= ~pick;
            gnt1    <= pick;
            busy    <= 1'b1;
            sel_q   <= pick;
            ptr_q   <= ~pick;
            wa_q    <= pick ? a1 : a0;
            wb_q    <= pick ? b1 : b0;
            carry_q <= pick ? ci1 : ci0;
            wsum_q  <= '0;
            k_q     <= '0;
            state_q <= StAdd;
          end
        end
        StAdd: begin
          wsum_q  <= wsum_upd;
          carry_q <= slice_co;
          k_q     <= k_q + 1'b1;
          if (k_q == KLast) begin
            // Publish the full result together with the last slice.
            sum     <= wsum_upd;
            co      <= slice_co;
            owner   <= sel_q;
            done    <= 1'b1;
            k_q     <= '0;
            state_q <= StDone;
          end
        end
        StDone: begin
          busy    <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_sum_arb_seq.sv
// Self-checking bench for sum_arb_seq: directed vectors, random transactions
// against an arithmetic model, and arbitration/reset sequences.
module tb_sum_arb_seq;
  localparam int NIBBLES = 4;
  localparam int W = 4 * NIBBLES;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req0, req1;
  logic [W-1:0] a0, b0, a1, b1;
  logic         ci0, ci1;
  logic         gnt0, gnt1, busy, done, owner, co;
  logic [W-1:0] sum;

  int total = 0;
  int bad = 0;

  sum_arb_seq #(.NIBBLES(NIBBLES)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .a0(a0), .b0(b0), .ci0(ci0),
    .req1(req1), .a1(a1), .b1(b1), .ci1(ci1),
    .gnt0(gnt0), .gnt1(gnt1), .busy(busy), .done(done),
    .owner(owner), .sum(sum), .co(co)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit           who;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ci;
    logic [W-1:0] esum;
    logic         eco;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, " gnt0"}, gnt0, 0);
    check({tag, " gnt1"}, gnt1, 0);
    check({tag, " busy"}, busy, 0);
    check({tag, " done"}, done, 0);
    check({tag, " sum"}, sum, 0);
    check({tag, " co"}, co, 0);
    check({tag, " owner"}, owner, 0);
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge of the done cycle.
  task automatic run_txn(input bit who, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic ci, input logic [W-1:0] esum, input logic eco,
                         input string tag);
    logic [W-1:0] held;
    bit seen, stable;
    int n;
    if (who) begin a1 = a; b1 = b; ci1 = ci; req1 = 1'b1; end
    else     begin a0 = a; b0 = b; ci0 = ci; req0 = 1'b1; end
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (gnt0 | gnt1) begin seen = 1; break; end
    end
    check({tag, " grant seen"}, seen, 1);
    req0 = 1'b0;
    req1 = 1'b0;
    if (!seen) return;
    check({tag, " gnt0"}, gnt0, !who);
    check({tag, " gnt1"}, gnt1, who);
    check({tag, " busy at gnt"}, busy, 1);
    held = sum;
    stable = 1;
    n = 0;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n++;
      if (done) begin seen = 1; break; end
      if (sum !== held) stable = 0;
    end
    check({tag, " done seen"}, seen, 1);
    check({tag, " latency"}, n, NIBBLES);
    check({tag, " sum held during add"}, stable, 1);
    check({tag, " sum"}, sum, esum);
    check({tag, " co"}, co, eco);
    check({tag, " owner"}, owner, who);
  endtask

  initial begin
    logic [W:0]   full;
    logic [W-1:0] ra, rb;
    logic         rci;
    bit           rwho;
    bit           ptr;
    bit           exp_q[$];
    int           grants, dones, last_g, waitcnt;
    bit           flag;

    vecs[0] = '{0, 16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0};
    vecs[1] = '{1, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1};
    vecs[2] = '{0, 16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0};
    vecs[3] = '{0, 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1};
    vecs[4] = '{1, 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1};
    vecs[5] = '{0, 16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0};
    vecs[6] = '{1, 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1};

    rst_n = 1'b0;
    req0 = 0; req1 = 0;
    a0 = '0; b0 = '0; ci0 = 0; a1 = '0; b1 = '0; ci1 = 0;
    #12;
    check_idle_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++)
      run_txn(vecs[i].who, vecs[i].a, vecs[i].b, vecs[i].ci, vecs[i].esum, vecs[i].eco,
              $sformatf("vec%0d", i));

    for (int i = 0; i < 30; i++) begin
      rwho = 1'($urandom_range(0, 1));
      ra   = W'($urandom);
      rb   = W'($urandom);
      rci  = 1'($urandom_range(0, 1));
      full = {1'b0, ra} + {1'b0, rb} + (W+1)'(rci);
      run_txn(rwho, ra, rb, rci, full[W-1:0], full[W], $sformatf("rand%0d", i));
    end

    // Both requesters held after reset: grants alternate starting with requester 0.
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    a0 = 16'h1234; b0 = 16'h4321; ci0 = 1'b0;
    a1 = 16'hA5A5; b1 = 16'h5A5A; ci1 = 1'b1;
    req0 = 1'b1; req1 = 1'b1;
    ptr = 0; grants = 0; dones = 0; last_g = 0;
    for (int cyc = 1; cyc <= 40 && dones < 3; cyc++) begin
      @(negedge clk);
      if (gnt0 | gnt1) begin
        check("both gnt", gnt0 & gnt1, 0);
        check("rr grant index", gnt1, ptr);
        if (grants == 0) check("first grant cycle", cyc, 1);
        else check("grant spacing", cyc - last_g, NIBBLES + 2);
        exp_q.push_back(ptr);
        ptr = !ptr;
        last_g = cyc;
        grants++;
      end
      if (done) begin
        check("done with gnt", gnt0 | gnt1, 0);
        if (exp_q.size() == 0) begin
          check("done without grant", 1, 0);
        end else begin
          rwho = exp_q.pop_front();
          full = rwho ? ({1'b0, a1} + {1'b0, b1} + 17'(ci1))
                      : ({1'b0, a0} + {1'b0, b0} + 17'(ci0));
          check("rr owner", owner, rwho);
          check("rr sum", sum, full[W-1:0]);
          check("rr co", co, full[W]);
        end
        dones++;
      end
    end
    check("rr dones", dones, 3);
    req0 = 0; req1 = 0;
    @(negedge clk);

    // req1 toggling while busy must not be granted until the FSM is idle again.
    a0 = 16'h0102; b0 = 16'h0304; ci0 = 1'b0; req0 = 1'b1;
    flag = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (gnt0) begin flag = 1; break; end
    end
    check("toggle gnt0 seen", flag, 1);
    req0 = 1'b0;
    flag = 0;
    for (int i = 0; i < 20; i++) begin
      req1 = !req1;
      @(negedge clk);
      if (gnt1) flag = 1;
      if (done) break;
    end
    check("no gnt1 while busy", flag, 0);
    check("toggle sum", sum, 16'h0406);
    run_txn(1, 16'h7777, 16'h1111, 1'b1, 16'h8889, 1'b0, "after toggle");

    // Reset during the second ADD cycle aborts the operation.
    a0 = 16'hABCD; b0 = 16'h1111; ci0 = 1'b0; req0 = 1'b1;
    flag = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (gnt0) begin flag = 1; break; end
    end
    check("abort gnt0 seen", flag, 1);
    req0 = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_idle_outputs("mid-add reset");
    @(negedge clk);
    rst_n = 1'b1;
    flag = 0;
    waitcnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done | busy) flag = 1;
      waitcnt++;
    end
    check("no done after abort", flag, 0);
    run_txn(0, 16'h2222, 16'h3333, 1'b1, 16'h5556, 1'b0, "post abort");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
